fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-cycle sequencer and fetch stage for the 4004 core. Sits directly upstream of the decoder.
- Generates the 8-phase cycle count (A1..X3 = 0..7) and the program counter.
- Fetches ROM bytes and presents opr/opa.
- Tracks two-word instructions and captures the second byte as an immediate.

Parameters:
PC_W, 12, program counter / ROM address width
RESET_PC, 12'h000, PC value after reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
run  in  1  clock enable; 0 freezes all state
romData  in  8  ROM byte at romAddr, combinational
pcLoad  in  1  jump request from execute, sampled only at cycle 7
pcLoadAddr  in  12  jump target
romAddr  out  12  current PC driven to ROM
cycle  out  3  phase 0=A1,1=A2,2=A3,3=M1,4=M2,5=X1,6=X2,7=X3
sync  out  1  high while cycle==7
opr  out  4  instruction upper nibble
opa  out  4  instruction lower nibble
secondWord  out  1  current instruction cycle is fetching word 2
immByte  out  8  second-word byte
instrDone  out  1  one-clock pulse at cycle 7 of the final word of an instruction

Behaviour:
- Reset (async, rst=1):
  - cycle=0, pc=RESET_PC.
  - opr=0, opa=0, immByte=0, secondWord=0, instrDone=0, state=FIRST.
  - sync=0.
  - Any in-flight two-word instruction is abandoned; the next fetch is a first word at RESET_PC.
- run=0: no register changes. Outputs hold and cycle does not advance. Resumes exactly where it stopped.
- Cycle counter: increments by 1 per enabled clock and wraps 7->0. romAddr=pc throughout.
- Fetch, state FIRST:
  - cycle==3 edge: opr<=romData[7:4]; visible from M2.
  - cycle==4 edge: opa<=romData[3:0]; visible from X1.
- Fetch, state SECOND:
  - opr/opa hold the first word's values.
  - cycle==3 edge: immByte[7:4]<=romData[7:4].
  - cycle==4 edge: immByte[3:0]<=romData[3:0].
- Two-word detect: evaluated at the cycle==4 edge in FIRST, using opr and romData[3:0]. Two-word opcodes:
  - opr=1 (JCN)
  - opr=2 with opa[0]=0 (FIM)
  - opr=4 (JUN)
  - opr=5 (JMS)
  - opr=7 (ISZ)
  - All other codes, including opr=2 with opa[0]=1 (SRC), are one-word.
- State machine, evaluated at the cycle==7 edge:
  - FIRST and two-word -> SECOND; secondWord<=1 from the next A1. instrDone stays low.
  - FIRST and one-word -> FIRST.
  - SECOND -> FIRST; secondWord<=0.
- instrDone: combinational, equals cycle==7 && (state==SECOND || !twoWordLatched).
- PC update at the cycle==7 edge:
  - If instrDone && pcLoad: pc<=pcLoadAddr.
  - Otherwise: pc<=pc+1, wrapping 12'hFFF->12'h000.
  - pcLoad during the first word of a two-word instruction is ignored; word 2 must be fetched.
  - pcLoad at cycles 0..6 is ignored.
- immByte retains its value until the next second-word fetch.

Optional Feature:
Macro SEQ_STEP_EN.
- Defined:
  - Adds input stepReq (1 bit).
  - Once cycle reaches 0 (A1), the counter halts there until a stepReq pulse with run=1.
  - Each pulse executes exactly one instruction cycle (8 clocks), then halts again at A1.
  - stepReq asserted while running is ignored.
  - After reset the block is halted at A1.
- Undefined: the port is absent and the counter free-runs under run.

Test Plan:
- Reset, rst=1 held 3 clocks mid-cycle -> all outputs 0, pc=0x000; after release, cycle counts 0..7 and sync is high only at 7.
- ROM all 0x00 (NOP), run=1 -> pc increments by 1 every 8 clocks; instrDone pulses every 8th clock; secondWord stays 0.
- ROM[0]=0xD5 (LDM 5) -> opr=D valid at cycle 4, opa=5 valid at cycle 5; secondWord=0; pc=1 after the first X3.
- ROM[0]=0x42, ROM[1]=0x34 (JUN 0x234):
  - secondWord=1 during clocks 8..15.
  - immByte=0x34 by cycle 5 of the second cycle.
  - pcLoad=1, pcLoadAddr=0x234 held from clock 0 -> ignored at clock 7 (pc=1), applied at clock 15 -> pc=0x234.
- ROM[0]=0x20 then ROM[1]=0xAB (FIM, two-word) vs ROM[0]=0x21 (SRC) -> FIM gives secondWord=1 and immByte=0xAB; SRC gives secondWord=0 and pc advances by 1.
- pc preloaded via jump to 0xFFF with ROM 0x00 -> pc wraps to 0x000 at the next X3; run=0 for 5 clocks at cycle 3 -> cycle, pc and opr are all frozen, and fetch resumes correctly.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-cycle sequencer and fetch stage for the 4004 core (8-phase counter, PC, opr/opa, immediate).
// Define SEQ_STEP_EN to add stepReq: the counter then halts at A1 and runs one instruction cycle per pulse.
module fetch_sequencer #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
`ifdef SEQ_STEP_EN
    input  logic            stepReq,
`endif
    input  logic [7:0]      romData,
    input  logic            pcLoad,
    input  logic [PC_W-1:0] pcLoadAddr,
    output logic [PC_W-1:0] romAddr,
    output logic [2:0]      cycle,
    output logic            sync,
    output logic [3:0]      opr,
    output logic [3:0]      opa,
    output logic            secondWord,
    output logic [7:0]      immByte,
    output logic            instrDone
);

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } wordStateT;

    wordStateT       state;
    wordStateT       stateNext;
    logic [PC_W-1:0] pc;
    logic            twoWordLatched;
    logic            advance;
    logic            endOfCycle;

    // JCN, FIM, JUN, JMS and ISZ carry a second byte; SRC shares opr=2 but has opa[0]=1.
    function automatic logic isTwoWord(input logic [3:0] code, input logic [3:0] low);
        logic result;
        case (code)
            4'h1, 4'h4, 4'h5, 4'h7: result = 1'b1;
            4'h2:                   result = ~low[0];
            default:                result = 1'b0;
        endcase
        return result;
    endfunction

`ifdef SEQ_STEP_EN
    // Parked at A1 until a step pulse; any other phase always runs on to the next A1.
    assign advance = run && ((cycle != 3'd0) || stepReq);
`else
    assign advance = run;
`endif

    assign endOfCycle = advance && (cycle == 3'd7);
    assign romAddr    = pc;
    assign sync       = (cycle == 3'd7);
    assign secondWord = (state == SECOND);
    assign instrDone  = (cycle == 3'd7) && ((state == SECOND) || !twoWordLatched);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle <= 3'd0;
        end else if (advance) begin
            cycle <= cycle + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FIRST;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (endOfCycle) begin
            case (state)
                FIRST:   stateNext = twoWordLatched ? SECOND : FIRST;
                SECOND:  stateNext = FIRST;
                default: stateNext = FIRST;
            endcase
        end
    end

    // A jump is only honoured on the last word, so word 2 of a two-word op is always fetched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (endOfCycle) begin
            if (instrDone && pcLoad) begin
                pc <= pcLoadAddr;
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opr            <= 4'h0;
            opa            <= 4'h0;
            immByte        <= 8'h00;
            twoWordLatched <= 1'b0;
        end else if (advance) begin
            if (state == FIRST) begin
                if (cycle == 3'd3) begin
                    opr <= romData[7:4];
                end
                if (cycle == 3'd4) begin
                    opa            <= romData[3:0];
                    twoWordLatched <= isTwoWord(opr, romData[3:0]);
                end
            end else begin
                if (cycle == 3'd3) begin
                    immByte[7:4] <= romData[7:4];
                end
                if (cycle == 3'd4) begin
                    immByte[3:0] <= romData[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random ROM/run/jump traffic against an instruction-level model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        pcLoad = 1'b0;
    logic [11:0] pcLoadAddr = 12'h000;
    logic [7:0]  romData;
    logic [11:0] romAddr;
    logic [2:0]  cycle;
    logic        sync;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic        secondWord;
    logic [7:0]  immByte;
    logic        instrDone;
`ifdef SEQ_STEP_EN
    logic        stepReq = 1'b1;
`endif

    logic [7:0]  rom [0:4095];
    assign romData = rom[romAddr];

    fetch_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
`ifdef SEQ_STEP_EN
        .stepReq    (stepReq),
`endif
        .romData    (romData),
        .pcLoad     (pcLoad),
        .pcLoadAddr (pcLoadAddr),
        .romAddr    (romAddr),
        .cycle      (cycle),
        .sync       (sync),
        .opr        (opr),
        .opa        (opa),
        .secondWord (secondWord),
        .immByte    (immByte),
        .instrDone  (instrDone)
    );

    always #5 clk = ~clk;

    // Model state: phase within the instruction cycle, address/word kind of the current cycle,
    // last first-word byte and last immediate byte.
    int          mPhase;
    logic [11:0] winPc;
    bit          winSecond;
    logic [7:0]  prevFirst;
    logic [7:0]  prevImm;
    int          nCmp = 0;
    int          nMis = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        nCmp++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit isTwo(input logic [7:0] b);
        int hi;
        hi = int'(b[7:4]);
        return (hi == 1) || (hi == 4) || (hi == 5) || (hi == 7) || (hi == 2 && b[0] == 1'b0);
    endfunction

    task automatic modelReset();
        mPhase    = 0;
        winPc     = 12'h000;
        winSecond = 0;
        prevFirst = 8'h00;
        prevImm   = 8'h00;
    endtask

    // Close one instruction cycle: decide whether the instruction ended and where the next fetch goes.
    task automatic endWindow();
        logic [7:0] b;
        bit         done;
        b = rom[winPc];
        if (winSecond) begin
            prevImm = b;
            done    = 1;
        end else begin
            prevFirst = b;
            done      = !isTwo(b);
        end
        if (done && pcLoad) winPc = pcLoadAddr;
        else                winPc = winPc + 12'd1;
        winSecond = !done;
    endtask

    task automatic checkOutputs();
        logic [7:0] b;
        logic [7:0] expImm;
        b = rom[winPc];
        chk("cycle", 16'(cycle), 16'(mPhase));
        chk("sync", 16'(sync), 16'(mPhase == 7));
        chk("romAddr", 16'(romAddr), 16'(winPc));
        chk("secondWord", 16'(secondWord), 16'(winSecond));
        chk("opr", 16'(opr), 16'((!winSecond && mPhase >= 4) ? b[7:4] : prevFirst[7:4]));
        chk("opa", 16'(opa), 16'((!winSecond && mPhase >= 5) ? b[3:0] : prevFirst[3:0]));
        expImm = prevImm;
        if (winSecond && mPhase >= 4) expImm[7:4] = b[7:4];
        if (winSecond && mPhase >= 5) expImm[3:0] = b[3:0];
        chk("immByte", 16'(immByte), 16'(expImm));
        chk("instrDone", 16'(instrDone), 16'(mPhase == 7 && (winSecond || !isTwo(b))));
    endtask

    task automatic tick();
        @(posedge clk);
        if (run) begin
            if (mPhase == 7) endWindow();
            mPhase = (mPhase + 1) % 8;
        end
        #1 checkOutputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_cycle"}, 16'(cycle), 16'h0);
        chk({tag, "_romAddr"}, 16'(romAddr), 16'h000);
        chk({tag, "_sync"}, 16'(sync), 16'h0);
        chk({tag, "_opr"}, 16'(opr), 16'h0);
        chk({tag, "_opa"}, 16'(opa), 16'h0);
        chk({tag, "_imm"}, 16'(immByte), 16'h0);
        chk({tag, "_second"}, 16'(secondWord), 16'h0);
        chk({tag, "_done"}, 16'(instrDone), 16'h0);
    endtask

    // Assert reset mid-clock, hold it across three edges, release on a falling edge.
    task automatic doReset();
        #2 rst = 1'b1;
        #1 checkReset("rstAsync");
        repeat (3) @(posedge clk);
        #1 checkReset("rstHeld");
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic clearRom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    initial begin
        clearRom();
        modelReset();

        // Reset, then a plain count of phases 0..7.
        run = 1'b1;
        doReset();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("phaseCount", 16'(cycle), 16'((i + 1) % 8));
        end

        // NOPs: PC advances once per eight clocks.
        doReset();
        ticks(24);
        chk("nopPc", 16'(romAddr), 16'h003);
        chk("nopSecond", 16'(secondWord), 16'h0);

        // LDM 5.
        rom[0] = 8'hD5;
        doReset();
        ticks(4);
        chk("ldmOpr", 16'(opr), 16'hD);
        tick();
        chk("ldmOpa", 16'(opa), 16'h5);
        ticks(3);
        chk("ldmPc", 16'(romAddr), 16'h001);

        // JUN 0x234 with the jump request held from clock 0.
        rom[0] = 8'h42; rom[1] = 8'h34;
        pcLoad = 1'b1; pcLoadAddr = 12'h234;
        doReset();
        ticks(8);
        chk("junPcWord1", 16'(romAddr), 16'h001);
        chk("junSecond", 16'(secondWord), 16'h1);
        ticks(5);
        chk("junImm", 16'(immByte), 16'h34);
        ticks(3);
        chk("junTarget", 16'(romAddr), 16'h234);
        chk("junSecondOff", 16'(secondWord), 16'h0);
        pcLoad = 1'b0;

        // FIM (two-word) vs SRC (one-word).
        rom[0] = 8'h20; rom[1] = 8'hAB;
        doReset();
        ticks(8);
        chk("fimSecond", 16'(secondWord), 16'h1);
        ticks(8);
        chk("fimImm", 16'(immByte), 16'hAB);
        chk("fimPc", 16'(romAddr), 16'h002);
        rom[0] = 8'h21;
        doReset();
        ticks(8);
        chk("srcSecond", 16'(secondWord), 16'h0);
        chk("srcPc", 16'(romAddr), 16'h001);

        // Jump to 0xFFF, wrap to 0x000, then freeze at M1 with run low.
        clearRom();
        rom[0] = 8'h9C;
        doReset();
        pcLoad = 1'b1; pcLoadAddr = 12'hFFF;
        ticks(8);
        chk("jumpFFF", 16'(romAddr), 16'hFFF);
        pcLoad = 1'b0;
        ticks(8);
        chk("wrapPc", 16'(romAddr), 16'h000);
        ticks(3);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frozenCycle", 16'(cycle), 16'h3);
            chk("frozenPc", 16'(romAddr), 16'h000);
        end
        run = 1'b1;
        tick();
        chk("resumeOpr", 16'(opr), 16'h9);
        tick();
        chk("resumeOpa", 16'(opa), 16'hC);

        // Random ROM, run gaps, jump requests and occasional mid-cycle resets.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
            doReset();
            for (int n = 0; n < 600; n++) begin
                run        = ($urandom_range(0, 9) != 0);
                pcLoad     = ($urandom_range(0, 2) == 0);
                pcLoadAddr = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 15)) : 12'($urandom);
                if ($urandom_range(0, 299) == 0) doReset();
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

endmodule
